// File: rtl/lsu_align_if.sv
// Core-side request/response and data-memory port signals of the load/store alignment unit.
interface lsu_align_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // The unit itself.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    // Core plus data memory surrounding the unit.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment unit: byte-lane steering, sub-word extension and
// req/ack sequencing toward a word-addressed data memory.
module lsu_align #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic        clk,
    input logic        rst_n,
    lsu_align_if.slave bus
);
    localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       off_q, off_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    // Reserved funct3 codes, unsigned stores and naturally misaligned accesses.
    function automatic logic illegal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) bad = 1'b1;
        if (we && f3[2]) bad = 1'b1;
        if (f3[1:0] == 2'b01 && off[0]) bad = 1'b1;
        if (f3[1:0] == 2'b10 && off != 2'b00) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] steer_data(input logic [1:0] sz, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] m;
        case (sz)
            2'b00:   m = {24'd0, w[7:0]};
            2'b01:   m = {16'd0, w[15:0]};
            default: m = w;
        endcase
        return m << {off, 3'b000};
    endfunction

    function automatic logic [3:0] steer_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] d);
        logic [31:0] s;
        logic [31:0] r;
        s = d >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{s[7]}}, s[7:0]};
            3'b001:  r = {{16{s[15]}}, s[15:0]};
            3'b100:  r = {24'd0, s[7:0]};
            3'b101:  r = {16'd0, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next state and next registered outputs; the memory port holds its value
    // for the whole ACCESS phase and is cleared on leaving it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    funct3_d = bus.req_funct3;
                    off_d    = bus.req_addr[1:0];
                    if (illegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_we;
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_wdata_d = bus.req_we ? steer_data(bus.req_funct3[1:0], bus.req_addr[1:0],
                                                              bus.req_wdata) : 32'd0;
                        mem_be_d    = bus.req_we ? steer_be(bus.req_funct3[1:0], bus.req_addr[1:0])
                                                 : 4'b1111;
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mem_we_q ? 32'd0 : load_extend(funct3_q, off_q, bus.mem_rdata);
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (state_d == RESP) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_be_d    = '0;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.stall     = (state_q != IDLE);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
